// File: rtl/isp_csc_matrix_if.sv
// Pixel bus for the CSC matrix: line/frame sync plus three components.
// master drives the bus, slave samples it.
interface isp_csc_matrix_if #(
  parameter int BITS = 8
);
  logic            href;
  logic            vsync;
  logic [BITS-1:0] c0;
  logic [BITS-1:0] c1;
  logic [BITS-1:0] c2;

  modport master (
    output href, vsync, c0, c1, c2
  );
  modport slave (
    input  href, vsync, c0, c1, c2
  );
endinterface

// File: rtl/isp_csc_matrix.sv
// Programmable 3x3 CSC matrix, 3-cycle pipeline, frame-synced config.
// Optional ISP_CSC_MATRIX_ROUND_EN: round-half-up instead of floor.
module isp_csc_matrix #(
  parameter int BITS      = 8,
  parameter int COEF_BITS = 12,
  parameter int FRAC      = 8,
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 960
) (
  input  logic                      pclk,
  input  logic                      rst,
  isp_csc_matrix_if.slave           src,
  isp_csc_matrix_if.master          dst,
  input  logic [9*COEF_BITS-1:0]    cfg_coef,
  input  logic [3*(BITS+1)-1:0]     cfg_offset,
  input  logic                      cfg_bypass,
  output logic                      active_bypass
);

  localparam int PW = COEF_BITS + BITS + 1;
  localparam int AW = BITS + COEF_BITS + 3;

  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [AW-1:0] acc_t;

  localparam acc_t MAXV = acc_t'((1 << BITS) - 1);
`ifdef ISP_CSC_MATRIX_ROUND_EN
  localparam acc_t RND = acc_t'(1) <<< (FRAC - 1);
`else
  localparam acc_t RND = '0;
`endif

  if (BITS < 8 || BITS > 12 || FRAC < 1 ||
      FRAC >= COEF_BITS || WIDTH < 1 || HEIGHT < 1) begin : g_bad_param
    $error("isp_csc_matrix: bad parameters");
  end

  logic [BITS-1:0] cin [3];
  assign cin[0] = src.c0;
  assign cin[1] = src.c1;
  assign cin[2] = src.c2;

  logic                        vs_q;
  logic                        load;
  logic                        byp_a;
  logic signed [COEF_BITS-1:0] coef_a [9];
  logic signed [BITS:0]        off_a  [3];

  assign load          = src.vsync & ~vs_q;
  assign active_bypass = byp_a;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_q  <= 1'b0;
      byp_a <= 1'b0;
      for (int k = 0; k < 9; k++) coef_a[k] <= '0;
      for (int i = 0; i < 3; i++) off_a[i] <= '0;
    end else begin
      vs_q <= src.vsync;
      if (load) begin
        byp_a <= cfg_bypass;
        for (int k = 0; k < 9; k++)
          coef_a[k] <= cfg_coef[k*COEF_BITS +: COEF_BITS];
        for (int i = 0; i < 3; i++)
          off_a[i] <= cfg_offset[i*(BITS+1) +: BITS+1];
      end
    end
  end

  prod_t                p1  [9];
  logic signed [BITS:0] o1  [3];
  logic [BITS-1:0]      d1  [3];
  logic [BITS-1:0]      d2  [3];
  logic [BITS-1:0]      c3  [3];
  acc_t                 acc2 [3];
  acc_t                 res [3];
  logic [BITS-1:0]      sat [3];
  logic                 h1, h2, h3;
  logic                 v1, v2, v3;
  logic                 b1, b2;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      res[i] = acc2[i] >>> FRAC;
      sat[i] = res[i][BITS-1:0];
      if (res[i] < 0)         sat[i] = '0;
      else if (res[i] > MAXV) sat[i] = '1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      {h1, h2, h3, v1, v2, v3, b1, b2} <= '0;
      for (int k = 0; k < 9; k++) p1[k] <= '0;
      for (int i = 0; i < 3; i++) begin
        o1[i]   <= '0;
        d1[i]   <= '0;
        d2[i]   <= '0;
        acc2[i] <= '0;
        c3[i]   <= '0;
      end
    end else begin
      h1 <= src.href;
      h2 <= h1;
      h3 <= h2;
      v1 <= src.vsync;
      v2 <= v1;
      v3 <= v2;
      b1 <= byp_a;
      b2 <= b1;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++)
          p1[3*i+j] <= prod_t'(coef_a[3*i+j]) *
                       prod_t'($signed({1'b0, cin[j]}));
        o1[i] <= off_a[i];
        d1[i] <= cin[i];
        d2[i] <= d1[i];
        acc2[i] <= acc_t'(p1[3*i]) + acc_t'(p1[3*i+1]) +
                   acc_t'(p1[3*i+2]) +
                   (acc_t'(o1[i]) <<< FRAC) + RND;
        // blanking wins over both bypass and matrix paths
        if (!h2)     c3[i] <= '0;
        else if (b2) c3[i] <= d2[i];
        else         c3[i] <= sat[i];
      end
    end
  end

  assign dst.href  = h3;
  assign dst.vsync = v3;
  assign dst.c0    = c3[0];
  assign dst.c1    = c3[1];
  assign dst.c2    = c3[2];

endmodule

// File: tb/tb_isp_csc_matrix.sv
// Randomized scoreboard bench for isp_csc_matrix.
// Reference model works on plain integers with floor division.
module tb_isp_csc_matrix;
  localparam int BITS = 8;
  localparam int CB   = 12;
  localparam int FRAC = 8;
  localparam int MAXC = (1 << BITS) - 1;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  isp_csc_matrix_if #(.BITS(BITS)) src_if ();
  isp_csc_matrix_if #(.BITS(BITS)) dst_if ();

  logic [9*CB-1:0]       cfg_coef   = '0;
  logic [3*(BITS+1)-1:0] cfg_offset = '0;
  logic                  cfg_bypass = 1'b0;
  logic                  active_bypass;

  isp_csc_matrix #(
    .BITS(BITS), .COEF_BITS(CB), .FRAC(FRAC)
  ) dut (
    .pclk          (pclk),
    .rst           (rst),
    .src           (src_if),
    .dst           (dst_if),
    .cfg_coef      (cfg_coef),
    .cfg_offset    (cfg_offset),
    .cfg_bypass    (cfg_bypass),
    .active_bypass (active_bypass)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int at;
    int c0;
    int c1;
    int c2;
  } exp_t;
  exp_t sbq[$];
  bit   vs_hist[int];

  int sh_coef[9];
  int sh_off[3];
  bit sh_byp;
  int act_coef[9];
  int act_off[3];
  bit act_byp;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic int floor_div(int a, int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model_c(int i, int r, int g, int b);
    int acc;
    int res;
    int px[3];
    px[0] = r; px[1] = g; px[2] = b;
    if (act_byp) return px[i];
    acc = act_coef[3*i] * r + act_coef[3*i+1] * g +
          act_coef[3*i+2] * b + act_off[i] * (1 << FRAC);
`ifdef ISP_CSC_MATRIX_ROUND_EN
    acc = acc + (1 << (FRAC - 1));
`endif
    res = floor_div(acc, 1 << FRAC);
    if (res < 0) res = 0;
    if (res > MAXC) res = MAXC;
    return res;
  endfunction

  task automatic set_cfg(int m[9], int o[3], bit byp);
    for (int k = 0; k < 9; k++) begin
      sh_coef[k] = m[k];
      cfg_coef[k*CB +: CB] = CB'(m[k]);
    end
    for (int i = 0; i < 3; i++) begin
      sh_off[i] = o[i];
      cfg_offset[i*(BITS+1) +: BITS+1] = (BITS+1)'(o[i]);
    end
    sh_byp = byp;
    cfg_bypass = byp;
  endtask

  task automatic pix(int r, int g, int b);
    exp_t e;
    @(posedge pclk); #1;
    src_if.href  = 1'b1;
    src_if.vsync = 1'b0;
    src_if.c0 = BITS'(r);
    src_if.c1 = BITS'(g);
    src_if.c2 = BITS'(b);
    e.at = cyc + 3;
    e.c0 = model_c(0, r, g, b);
    e.c1 = model_c(1, r, g, b);
    e.c2 = model_c(2, r, g, b);
    sbq.push_back(e);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge pclk); #1;
      src_if.href  = 1'b0;
      src_if.vsync = 1'b0;
      src_if.c0 = BITS'($urandom);
      src_if.c1 = BITS'($urandom);
      src_if.c2 = BITS'($urandom);
    end
  endtask

  task automatic vs_pulse(int len, bit scramble);
    for (int n = 0; n < len; n++) begin
      @(posedge pclk); #1;
      src_if.href  = 1'b0;
      src_if.vsync = 1'b1;
      if (n == 0) begin
        act_coef = sh_coef;
        act_off  = sh_off;
        act_byp  = sh_byp;
      end
      if (n == 1 && scramble) begin
        for (int k = 0; k < 9; k++) cfg_coef[k*CB +: CB] = CB'($urandom);
        cfg_bypass = ~cfg_bypass;
      end
    end
    idle(2);
    @(negedge pclk);
    check("active_bypass", int'(active_bypass), int'(act_byp));
  endtask

  task automatic rand_pixels(int n);
    for (int k = 0; k < n; k++) begin
      pix($urandom_range(MAXC), $urandom_range(MAXC), $urandom_range(MAXC));
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic check_zero_outs(string tag);
    check({tag, "_href"}, int'(dst_if.href), 0);
    check({tag, "_vsync"}, int'(dst_if.vsync), 0);
    check({tag, "_c0"}, int'(dst_if.c0), 0);
    check({tag, "_c1"}, int'(dst_if.c1), 0);
    check({tag, "_c2"}, int'(dst_if.c2), 0);
    check({tag, "_byp"}, int'(active_bypass), 0);
  endtask

  // monitor: pops one expectation per presented pixel
  always @(negedge pclk) begin
    exp_t e;
    vs_hist[cyc] = src_if.vsync;
    if (!rst) begin
      if (cyc >= 3) check("vsync_delay", int'(dst_if.vsync), int'(vs_hist[cyc-3]));
      while (sbq.size() > 0 && sbq[0].at < cyc) begin
        e = sbq.pop_front();
        check("missing_pixel", 0, 1);
      end
      if (dst_if.href) begin
        if (sbq.size() == 0) begin
          check("unexpected_href", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("latency", cyc, e.at);
          check("c0", int'(dst_if.c0), e.c0);
          check("c1", int'(dst_if.c1), e.c1);
          check("c2", int'(dst_if.c2), e.c2);
        end
      end else begin
        check("blank", int'({dst_if.c0, dst_if.c1, dst_if.c2}), 0);
      end
    end
  end

  int bt601_m[9] = '{77, 150, 29, -43, -85, 128, 128, -107, -21};
  int bt601_o[3] = '{0, 128, 128};
  int ident_m[9] = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
  int zero_o[3]  = '{0, 0, 0};
  int sat_m[9];
  int rnd_m[9];
  int rnd_o[3];

  initial begin
    src_if.href  = 1'b0;
    src_if.vsync = 1'b0;
    src_if.c0 = '0;
    src_if.c1 = '0;
    src_if.c2 = '0;
    act_coef = '{default: 0};
    act_off  = '{default: 0};
    act_byp  = 1'b0;
    set_cfg(bt601_m, bt601_o, 1'b0);
    repeat (2) @(negedge pclk);
    check_zero_outs("reset");
    @(posedge pclk); #1;
    rst = 1'b0;
    idle(3);

    // cleared active set before any frame start
    pix(255, 255, 255);
    idle(4);

    vs_pulse(1, 1'b0);
    pix(255, 255, 255);
    pix(255, 0, 0);
    idle(2);
    rand_pixels(20);

    // shadow change mid-line must not take effect yet
    set_cfg(ident_m, zero_o, 1'b0);
    rand_pixels(10);
    vs_pulse(6, 1'b1);
    pix(10, 20, 30);
    rand_pixels(10);

    sat_m = '{default: 0};
    sat_m[0] = 512;
    set_cfg(sat_m, zero_o, 1'b0);
    vs_pulse(1, 1'b0);
    pix(200, 0, 0);
    idle(1);
    sat_m[0] = -256;
    set_cfg(sat_m, zero_o, 1'b0);
    vs_pulse(1, 1'b0);
    pix(10, 0, 0);
    idle(2);

    for (int k = 0; k < 9; k++) rnd_m[k] = int'($urandom_range(4095)) - 2048;
    set_cfg(rnd_m, bt601_o, 1'b1);
    vs_pulse(2, 1'b0);
    rand_pixels(15);
    idle(5);

    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 9; k++) rnd_m[k] = int'($urandom_range(4095)) - 2048;
      for (int i = 0; i < 3; i++) rnd_o[i] = int'($urandom_range(511)) - 256;
      set_cfg(rnd_m, rnd_o, ($urandom_range(3) == 0));
      vs_pulse($urandom_range(1, 4), 1'b1);
      rand_pixels(30);
    end

    // reset in the middle of a line
    set_cfg(bt601_m, bt601_o, 1'b0);
    vs_pulse(1, 1'b0);
    pix(255, 255, 255);
    pix(12, 34, 56);
    @(posedge pclk); #1;
    rst = 1'b1;
    src_if.href = 1'b0;
    sbq.delete();
    act_coef = '{default: 0};
    act_off  = '{default: 0};
    act_byp  = 1'b0;
    #1;
    check_zero_outs("midreset");
    repeat (3) @(posedge pclk);
    #1;
    rst = 1'b0;
    idle(2);
    pix(255, 255, 255);
    idle(6);
    check("drain", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/isp_csc_matrix.md
Name: isp_csc_matrix

Overview:
- Programmable 3x3 color-space-conversion matrix for the ISP lite pipeline.
- Parametrised successor of the fixed RGB2YUV stage.
- Signed coefficients, per-channel signed offsets, saturation, bypass mode.
- Matrix configuration is double-buffered and takes effect only at frame start.
- Sits after the RGB processing stages (CCM/gamma) and feeds YUV consumers; the generic matrix also allows YUV2RGB or RGB→RGB.

Parameters:
- BITS, 8, pixel component width (8..12).
- COEF_BITS, 12, signed coefficient width, two's complement.
- FRAC, 8, fractional bits of the coefficients (1.0 = 1<<FRAC); FRAC < COEF_BITS.
- WIDTH, 1280, frame width; informational only.
- HEIGHT, 960, frame height; informational only.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_href  in  1  line-valid, qualifies in_c0..in_c2.
- in_vsync  in  1  frame sync, active-high; rising edge = frame start.
- in_c0  in  BITS  input component 0 (R).
- in_c1  in  BITS  input component 1 (G).
- in_c2  in  BITS  input component 2 (B).
- cfg_coef  in  9*COEF_BITS  shadow coefficients, row-major; [COEF_BITS-1:0] = M00, ..., top slice = M22.
- cfg_offset  in  3*(BITS+1)  shadow signed offsets O0..O2; O0 in the lowest slice.
- cfg_bypass  in  1  shadow bypass request.
- out_href  out  1  delayed in_href.
- out_vsync  out  1  delayed in_vsync.
- out_c0  out  BITS  output component 0 (Y).
- out_c1  out  BITS  output component 1 (U).
- out_c2  out  BITS  output component 2 (V).
- active_bypass  out  1  bypass state currently in effect.

Behaviour:
- Reset (async, rst=1): all pipeline registers, active coefficients, active offsets, active_bypass and delay lines clear to 0. All outputs read 0 while rst=1 and after release until new data arrives.
- Shadow load:
  - Active matrix, offsets and bypass copy cfg_* on the cycle a rising in_vsync edge is detected (in_vsync=1, registered previous=0).
  - The new set applies from the first pixel after that edge.
  - cfg_* changes at any other time do not affect output.
  - After reset the active set is all zero until the first vsync rising edge. In that state outputs are clamp(0) = 0 unless offsets are loaded.
- Arithmetic, per output row i:
  - Inputs are zero-extended.
  - acc_i = sum_j(Mij*in_cj) + (Oi << FRAC), signed, width BITS+COEF_BITS+3, with no overflow possible.
  - res_i = acc_i >>> FRAC (arithmetic shift, i.e. floor).
  - out_ci = 0 if res_i < 0; (2^BITS)-1 if res_i > (2^BITS)-1; otherwise res_i[BITS-1:0].
- Pipeline, fixed latency 3 cycles:
  - S1: nine registered products.
  - S2: registered row sums plus offset.
  - S3: registered shift/clamp.
- Sync delay:
  - in_href and in_vsync are delayed by exactly 3 cycles to out_href and out_vsync.
  - The pipeline runs every cycle with no stall and no back-pressure.
- Bypass (active_bypass=1):
  - out_ci = in_ci delayed 3 cycles, with no matrix applied.
  - Latency is unchanged, so toggling between frames causes no timing shift.
- Blanking: out_c0..out_c2 are forced to 0 whenever out_href=0.
- Consecutive identical edges: a vsync held high for many cycles loads once. A vsync rising edge in the same cycle as in_href=1 is still a valid load.
- Reset mid-frame:
  - Outputs go to 0 immediately and in-flight pixels are discarded.
  - After release, the first valid output appears 3 cycles after the next in_href=1.
  - The active set stays 0 until the next vsync rising edge.

Optional Feature:
- Macro ISP_CSC_MATRIX_ROUND_EN.
  - Defined: S2 adds (1 << (FRAC-1)) to each acc_i before the shift, giving round-half-up. Saturation still applies after rounding.
  - Undefined: truncation (floor) as specified above.
- Latency is 3 cycles in both builds.

Test Plan:
All scenarios use BITS=8, COEF_BITS=12, FRAC=8 and the BT601 set: M = [77,150,29; -43,-85,128; 128,-107,-21], O = [0,128,128], loaded by one vsync pulse.
- Basic: RGB (255,255,255) with href=1 → 3 cycles later YUV = (255,128,128); out_href rises exactly 3 cycles after in_href.
- Red: RGB (255,0,0) → (76,85,255) without the macro; (77,85,255) with it, where V=255.5 rounds up and clamps to 255.
- Saturation: M00=512, other coefficients 0, O=0, R=200 → out_c0=255. M00=-256, R=10 → out_c0=0.
- Shadow: switch cfg_coef to identity (M00=M11=M22=256) mid-line → output unchanged until the next vsync rise; afterwards RGB (10,20,30) → (10,20,30).
- Bypass and blanking: cfg_bypass=1 then vsync → active_bypass=1 and out equals in delayed 3 cycles. With href=0 all out_c = 0 regardless of inputs.
- Reset: assert rst mid-line → all outputs 0 in the same cycle. After release with no vsync, RGB (255,255,255) → (0,0,0) because the active set is cleared.
